// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, 2-flop synchronized input) feeding a small circular FIFO.
// Framing errors and full-FIFO drops are reported as one-cycle pulses.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH_LOG2   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rdreq,
  output logic [7:0] q,
  output logic       empty,
  output logic       full,
  output logic       overrun,
  output logic       frame_err
);

  localparam int                  DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [15:0]         BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0]         HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizer; both flops reset to the idle (high) line level
  // ---------------------------------------------------------------------------
  logic rx_meta_q;
  logic rx_s_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver FSM
  // ---------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        bits_done_q, bits_done_d;
  logic [7:0]  shift_q, shift_d;
  logic        push_q, push_d;
  logic        frame_err_q, frame_err_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      timer_q     <= 16'd0;
      bit_cnt_q   <= 3'd0;
      bits_done_q <= 1'b0;
      shift_q     <= 8'h00;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_cnt_q   <= bit_cnt_d;
      bits_done_q <= bits_done_d;
      shift_q     <= shift_d;
      push_q      <= push_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    bit_cnt_d   = bit_cnt_q;
    bits_done_d = bits_done_q;
    shift_d     = shift_q;
    push_d      = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        timer_d = 16'd0;
        if (!rx_s_q) begin
          state_d     = START;
          bit_cnt_d   = 3'd0;
          bits_done_d = 1'b0;
        end
      end

      START: begin
        // A start bit that is no longer low at its midpoint is a glitch.
        if (timer_q == HALF_LAST) begin
          timer_d = 16'd0;
          state_d = rx_s_q ? IDLE : DATA;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end

      DATA: begin
        if (timer_q == BIT_LAST) begin
          timer_d = 16'd0;
          shift_d = {rx_s_q, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            bits_done_d = 1'b1;
            state_d     = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end

      STOP: begin
        if (timer_q == BIT_LAST && bits_done_q) begin
          timer_d = 16'd0;
          state_d = IDLE;
          if (rx_s_q) begin
            push_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end

      default: begin
        state_d = IDLE;
        timer_d = 16'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Circular FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rptr_q;
  logic [DEPTH_LOG2-1:0] wptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic [7:0]            q_q;
  logic                  overrun_q;
  logic                  pop_ok;
  logic                  push_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_CNT);
  // A pop in the same cycle frees a slot, so a full FIFO can still take a push.
  assign pop_ok  = rdreq & ~empty;
  assign push_ok = push_q & (~full | pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr_q] <= shift_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rptr_q    <= '0;
      wptr_q    <= '0;
      count_q   <= '0;
      q_q       <= 8'h00;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= push_q & ~push_ok;
      if (pop_ok) begin
        q_q    <= mem[rptr_q];
        rptr_q <= rptr_q + 1'b1;
      end
      if (push_ok) begin
        wptr_q <= wptr_q + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign q         = q_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized bench for uart_rx_fifo: frames are scheduled into a queue-based
// model of the FIFO, which is compared against the DUT on every cycle.
module tb_uart_rx_fifo;

  localparam int CPB   = 8;
  localparam int DL2   = 2;
  localparam int DEPTH = 1 << DL2;
  // Edges from the first edge that sees the start bit to the stop-bit
  // mid-sample: 2 synchronizer stages, half a bit, then nine full bits.
  localparam int STOP_OFS = 2 + CPB / 2 + 9 * CPB;

  logic       clk;
  logic       reset;
  logic       rx;
  logic       rdreq;
  logic [7:0] q;
  logic       empty;
  logic       full;
  logic       overrun;
  logic       frame_err;

  uart_rx_fifo #(
    .CLKS_PER_BIT(CPB),
    .DEPTH_LOG2  (DL2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .rdreq    (rdreq),
    .q        (q),
    .empty    (empty),
    .full     (full),
    .overrun  (overrun),
    .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_ferr_seen = 0;
  int n_ovr_seen  = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Behavioural model: queue FIFO plus one scheduled frame outcome
  // ---------------------------------------------------------------------------
  logic [7:0] mq[$];
  logic [7:0] m_q = 8'h00;
  logic       m_ferr = 1'b0;
  logic       m_ovr = 1'b0;
  logic       pend_valid = 1'b0;
  int         pend_edge = 0;
  logic [7:0] pend_byte = 8'h00;
  logic       pend_stop = 1'b0;
  logic       push_pend = 1'b0;
  logic [7:0] push_byte = 8'h00;

  initial forever begin
    logic pop_ok, push_ok, do_push;
    @(posedge clk);
    cyc = cyc + 1;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    if (reset) begin
      mq.delete();
      m_q = 8'h00;
      pend_valid = 1'b0;
      push_pend  = 1'b0;
    end else begin
      pop_ok  = rdreq && (mq.size() != 0);
      do_push = push_pend;
      push_pend = 1'b0;
      push_ok = do_push && ((mq.size() < DEPTH) || pop_ok);
      if (pop_ok) m_q = mq.pop_front();
      if (push_ok) mq.push_back(push_byte);
      m_ovr = do_push && !push_ok;
      if (pend_valid && cyc == pend_edge) begin
        pend_valid = 1'b0;
        if (pend_stop) begin
          push_pend = 1'b1;
          push_byte = pend_byte;
        end else begin
          m_ferr = 1'b1;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (cyc > 0) begin
      chk("q", {24'd0, q}, {24'd0, m_q});
      chk("empty", {31'd0, empty}, {31'd0, (mq.size() == 0)});
      chk("full", {31'd0, full}, {31'd0, (mq.size() == DEPTH)});
      chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
      chk("frame_err", {31'd0, frame_err}, {31'd0, m_ferr});
      if (frame_err === 1'b1) n_ferr_seen++;
      if (overrun === 1'b1) n_ovr_seen++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (called #1 after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    pend_edge  = cyc + 1 + STOP_OFS;
    pend_byte  = b;
    pend_stop  = stop;
    pend_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    #1;
    $display("frame byte=%02h stop=%0d  q=%02h empty=%0d full=%0d", b, stop, q, empty, full);
  endtask

  task automatic pop_one(output logic [7:0] got);
    rdreq = 1'b1;
    @(posedge clk);
    #1;
    rdreq = 1'b0;
    got = q;
    $display("pop  q=%02h empty=%0d full=%0d", q, empty, full);
  endtask

  logic [7:0] got;
  logic [7:0] w[4];
  logic [7:0] nb;
  int         k;
  int         ferr0, ovr0;

  initial begin
    reset = 1'b1;
    rx    = 1'b1;
    rdreq = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_q", {24'd0, q}, 32'h00);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Single byte
    send_frame(8'hA5, 1'b1);
    chk("single_empty", {31'd0, empty}, 32'd0);
    pop_one(got);
    chk("single_q", {24'd0, got}, 32'hA5);
    chk("single_empty_after", {31'd0, empty}, 32'd1);

    // Glitch, then framing error
    ferr0 = n_ferr_seen;
    rx = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("glitch_empty", {31'd0, empty}, 32'd1);
    send_frame(8'h3C, 1'b0);
    chk("ferr_pulses", n_ferr_seen - ferr0, 32'd1);
    chk("ferr_empty", {31'd0, empty}, 32'd1);

    // Overrun
    ovr0 = n_ovr_seen;
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
    chk("ovr_full", {31'd0, full}, 32'd1);
    send_frame(8'h05, 1'b1);
    chk("ovr_pulses", n_ovr_seen - ovr0, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      pop_one(got);
      chk("ovr_pop_q", {24'd0, got}, i);
    end
    chk("ovr_empty", {31'd0, empty}, 32'd1);

    // Wrap and simultaneous push/pop while full
    for (int i = 0; i < 4; i++) begin
      w[i] = 8'($urandom);
      send_frame(w[i], 1'b1);
    end
    nb = 8'($urandom);
    k  = cyc + 1;
    fork
      send_frame(nb, 1'b1);
      begin
        wait (cyc == k + STOP_OFS);
        #1;
        rdreq = 1'b1;
        @(posedge clk);
        #1;
        rdreq = 1'b0;
        chk("conc_q", {24'd0, q}, {24'd0, w[0]});
      end
    join
    chk("conc_full", {31'd0, full}, 32'd1);
    for (int i = 1; i < 4; i++) begin
      pop_one(got);
      chk("wrap_q", {24'd0, got}, {24'd0, w[i]});
    end
    pop_one(got);
    chk("wrap_new_q", {24'd0, got}, {24'd0, nb});
    pop_one(got);
    chk("empty_rd_q", {24'd0, got}, {24'd0, nb});

    // Random traffic with random reads
    for (int f = 0; f < 12; f++) begin
      fork
        send_frame(8'($urandom), ($urandom_range(0, 7) != 0));
        begin
          for (int c = 0; c < 90; c++) begin
            rdreq = ($urandom_range(0, 2) == 0);
            @(posedge clk);
            #1;
          end
          rdreq = 1'b0;
        end
      join
    end
    for (int i = 0; i < DEPTH + 1; i++) pop_one(got);
    chk("drain_empty", {31'd0, empty}, 32'd1);

    // Reset in the middle of a frame
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (40) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
      end
    join
    chk("midrst_empty", {31'd0, empty}, 32'd1);
    send_frame(8'h5A, 1'b1);
    pop_one(got);
    chk("midrst_q", {24'd0, got}, 32'h5A);

    repeat (4) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
